// File: rtl/count_cmd_queue.sv
// -----------------------------------------------------------------------------
// count_cmd_queue
//
// Command buffer and sequencer feeding the Mode/Din control inputs of a 4-bit
// mode counter. Producers push {mode, data, repeat} commands through a
// valid/ready port into a small FIFO. Each command is then replayed on
// Mode/Din for Rep+1 consecutive clocks. When no work is queued, the block
// drives hold (Mode=00, Din=0000).
//
// Parameters:
//   DEPTH   FIFO entries (power of two, >= 2)
//   AW      log2(DEPTH)
//
// Ports:
//   Ck       in   1     clock, all state changes on posedge
//   Reset    in   1     synchronous active-high reset
//   InValid  in   1     producer presents a command
//   InReady  out  1     command accepted this cycle (from occupancy and Reset)
//   InMode   in   2     counter mode: 00 hold, 01 load, 10 up, 11 down
//   InDin    in   4     load data, carried with every mode
//   InRep    in   4     command is applied for InRep+1 cycles
//   Mode     out  2     registered mode to the counter
//   Din      out  4     registered data to the counter
//   Busy     out  1     a command is currently being applied
//   Level    out  AW+1  FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module count_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          Ck,
    input  logic          Reset,
    input  logic          InValid,
    output logic          InReady,
    input  logic [1:0]    InMode,
    input  logic [3:0]    InDin,
    input  logic [3:0]    InRep,
    output logic [1:0]    Mode,
    output logic [3:0]    Din,
    output logic          Busy,
    output logic [AW:0]   Level
);

    localparam int CMD_W = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [CMD_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [3:0]        rem;
    logic [CMD_W-1:0]  head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full  = (Level == (AW+1)'(DEPTH));
    assign empty = (Level == '0);

    // Ready depends only on registered occupancy and Reset, so a full queue
    // refuses a push even when a pop happens on the same edge.
    assign InReady = !full && !Reset;
    assign push    = InValid && InReady;

    // The head is popped when idle, or when the running command has spent its
    // last cycle; the latter gives back-to-back windows with no hold bubble.
    assign head = mem[rd_ptr];
    assign pop  = !empty && ((state == IDLE) || (rem == 4'd0));

    // ---- FIFO storage: data only, left out of reset ----
    always_ff @(posedge Ck) begin
        if (push) begin
            mem[wr_ptr] <= {InMode, InDin, InRep};
        end
    end

    // ---- Control: pointers, occupancy and issue FSM with registered outputs ----
    always_ff @(posedge Ck) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Level  <= '0;
            state  <= IDLE;
            rem    <= 4'd0;
            Mode   <= 2'b00;
            Din    <= 4'b0000;
            Busy   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   Level <= Level + 1'b1;
                2'b01:   Level <= Level - 1'b1;
                default: Level <= Level;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        Mode  <= head[9:8];
                        Din   <= head[7:4];
                        rem   <= head[3:0];
                        Busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rem != 4'd0) begin
                        rem <= rem - 1'b1;
                    end else if (pop) begin
                        Mode <= head[9:8];
                        Din  <= head[7:4];
                        rem  <= head[3:0];
                    end else begin
                        Mode  <= 2'b00;
                        Din   <= 4'b0000;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_count_cmd_queue
//
// Self-checking bench for count_cmd_queue. Accepted commands are pushed into
// a scoreboard queue. A monitor running on the falling edge pops each command
// when its replay window starts, then checks Mode/Din/Busy for every one of
// its Rep+1 cycles. Directed sequences check latency, occupancy, ready
// behaviour and reset. A small behavioural 4-bit mode counter follows
// Mode/Din so that end values can be checked.
// -----------------------------------------------------------------------------
module tb_count_cmd_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] din;
        logic [3:0] rep;
    } cmd_t;

    logic          Ck;
    logic          Reset;
    logic          InValid;
    logic          InReady;
    logic [1:0]    InMode;
    logic [3:0]    InDin;
    logic [3:0]    InRep;
    logic [1:0]    Mode;
    logic [3:0]    Din;
    logic          Busy;
    logic [AW:0]   Level;

    int   n_checks = 0;
    int   n_fail   = 0;
    cmd_t sb[$];
    cmd_t cur;
    int   cnt_left = 0;
    logic [3:0] ctr;
    logic       ctr_clr;

    count_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Ck      (Ck),
        .Reset   (Reset),
        .InValid (InValid),
        .InReady (InReady),
        .InMode  (InMode),
        .InDin   (InDin),
        .InRep   (InRep),
        .Mode    (Mode),
        .Din     (Din),
        .Busy    (Busy),
        .Level   (Level)
    );

    initial Ck = 1'b0;
    always #5 Ck = ~Ck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] d, input logic [3:0] r);
        InValid = v;
        InMode  = m;
        InDin   = d;
        InRep   = r;
    endtask

    task automatic tick();
        @(posedge Ck);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!(Busy == 1'b0 && Level == '0) && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_level"}, Level, 0);
    endtask

    // Behavioural mode counter consuming Mode/Din at each rising edge.
    always @(posedge Ck) begin
        if (ctr_clr) begin
            ctr <= 4'd0;
        end else begin
            case (Mode)
                2'b01:   ctr <= Din;
                2'b10:   ctr <= ctr + 4'd1;
                2'b11:   ctr <= ctr - 4'd1;
                default: ctr <= ctr;
            endcase
        end
    end

    // Scoreboard monitor: outputs and handshake are stable at the falling edge.
    always @(negedge Ck) begin
        if (cnt_left == 0 && Busy === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_busy", Busy, 0);
            end else begin
                cur      = sb.pop_front();
                cnt_left = int'(cur.rep) + 1;
            end
        end
        if (cnt_left != 0) begin
            chk("win_busy", Busy, 1);
            chk("win_mode", Mode, cur.mode);
            chk("win_din", Din, cur.din);
            cnt_left--;
        end else if (Busy === 1'b0) begin
            chk("idle_mode", Mode, 0);
            chk("idle_din", Din, 0);
        end
        if (Reset) begin
            sb.delete();
            cnt_left = 0;
        end else if (InValid && InReady) begin
            sb.push_back({InMode, InDin, InRep});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // ---------------- reset values ----------------
        ctr_clr = 1'b1;
        Reset   = 1'b1;
        drive(1'b1, 2'b01, 4'b1111, 4'd0);
        tick();
        tick();
        chk("rst_mode", Mode, 0);
        chk("rst_din", Din, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_level", Level, 0);
        chk("rst_ready", InReady, 0);
        Reset   = 1'b0;
        ctr_clr = 1'b0;
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        #1;
        chk("rel_ready", InReady, 1);
        tick();
        chk("rel_level", Level, 0);
        chk("rel_busy", Busy, 0);

        // ---------------- single command ----------------
        ctr_clr = 1'b1;
        tick();
        ctr_clr = 1'b0;
        drive(1'b1, 2'b01, 4'b1010, 4'd0);
        tick();                                 // edge k: push
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        chk("one_k_level", Level, 1);
        chk("one_k_busy", Busy, 0);
        chk("one_k_mode", Mode, 0);
        tick();                                 // edge k+1: pop
        chk("one_k1_mode", Mode, 2'b01);
        chk("one_k1_din", Din, 4'b1010);
        chk("one_k1_busy", Busy, 1);
        chk("one_k1_level", Level, 0);
        tick();                                 // edge k+2: counter loads
        chk("one_k2_mode", Mode, 0);
        chk("one_k2_din", Din, 0);
        chk("one_k2_busy", Busy, 0);
        chk("one_ctr", ctr, 4'd10);

        // ---------------- repeat and back-to-back ----------------
        ctr_clr = 1'b1;
        tick();
        ctr_clr = 1'b0;
        drive(1'b1, 2'b10, 4'b0101, 4'd3);
        tick();                                 // edge k
        chk("b2b_k_level", Level, 1);
        drive(1'b1, 2'b11, 4'b0011, 4'd1);
        tick();                                 // edge k+1
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        chk("b2b_k1_level", Level, 1);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_up_mode", Mode, 2'b10);
            chk("b2b_up_busy", Busy, 1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chk("b2b_dn_mode", Mode, 2'b11);
            chk("b2b_dn_busy", Busy, 1);
            tick();
        end
        chk("b2b_end_mode", Mode, 0);
        chk("b2b_end_busy", Busy, 0);
        chk("b2b_ctr", ctr, 4'd2);

        // ---------------- full boundary ----------------
        drive(1'b1, 2'b10, 4'b0001, 4'd15);
        tick();                                 // k: P0
        drive(1'b1, 2'b01, 4'b0010, 4'd1);
        tick();                                 // k+1: P0 popped, P1 pushed
        drive(1'b1, 2'b11, 4'b0011, 4'd0);
        tick();
        drive(1'b1, 2'b01, 4'b0100, 4'd2);
        tick();
        drive(1'b1, 2'b00, 4'b0101, 4'd0);
        tick();                                 // k+4: queue full
        chk("full_level", Level, 4);
        chk("full_ready", InReady, 0);
        chk("full_busy", Busy, 1);
        drive(1'b1, 2'b10, 4'b0110, 4'd0);      // 6th push held off
        n = 0;
        while (InReady !== 1'b1 && n < 40) begin
            chk("full_hold_level", Level, 4);
            tick();
            n++;
        end
        chk("full_wait_cycles", n, 13);
        chk("full_pop_level", Level, 3);
        tick();                                 // 6th push accepted
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        chk("full_refill_level", Level, 4);
        drain("full_drain");

        // ---------------- simultaneous push/pop ----------------
        drive(1'b1, 2'b10, 4'b1000, 4'd2);
        tick();                                 // k
        drive(1'b1, 2'b01, 4'b1001, 4'd0);
        tick();                                 // k+1
        drive(1'b1, 2'b11, 4'b1010, 4'd1);
        tick();                                 // k+2
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        tick();                                 // k+3
        chk("sim_pre_level", Level, 2);
        chk("sim_pre_mode", Mode, 2'b10);
        drive(1'b1, 2'b01, 4'b1011, 4'd0);
        tick();                                 // k+4: push and pop together
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        chk("sim_level", Level, 2);
        chk("sim_mode", Mode, 2'b01);
        chk("sim_din", Din, 4'b1001);
        drain("sim_drain");

        // ---------------- reset mid-operation ----------------
        drive(1'b1, 2'b10, 4'b0000, 4'd7);
        tick();
        drive(1'b1, 2'b01, 4'b0110, 4'd0);
        tick();
        drive(1'b1, 2'b11, 4'b0111, 4'd0);
        tick();
        drive(1'b1, 2'b01, 4'b1100, 4'd0);
        tick();                                 // 3rd cycle of the Rep=7 window
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        chk("mid_level", Level, 3);
        chk("mid_busy", Busy, 1);
        chk("mid_mode", Mode, 2'b10);
        Reset = 1'b1;
        #1;
        chk("mid_rst_ready", InReady, 0);
        tick();
        chk("mid_rst_mode", Mode, 0);
        chk("mid_rst_din", Din, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_level", Level, 0);
        Reset = 1'b0;
        #1;
        chk("mid_rel_ready", InReady, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_replay_busy", Busy, 0);
            chk("mid_no_replay_level", Level, 0);
        end

        // ---------------- scoreboard completeness ----------------
        tick();
        chk("sb_left", sb.size(), 0);
        chk("sb_window", cnt_left, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
